ex_mem_pipe_stage: RTL
======================

Name: ex_mem_pipe_stage

Overview:
- Parametrised successor to the fixed EX→MEM pipeline register.
- Carries the ALU result, store data, extended immediate, PC+4, write-back register index, write-back select and write enables from EX to MEM.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for full throughput under back-pressure, a synchronous flush for branch/exception squash, and a saturating stall counter.
- Sits between the EX datapath and the MEM stage / data-RAM interface.

Parameters:
- XLEN, 32, width of aluc/rD2/ext/pc4 fields.
- REG_AW, 5, width of the write-back register index.
- WSEL_W, 2, width of the write-back select field.
- SKID, 1. With 1, a 2-entry skid buffer is used and in_ready_o is purely registered. With 0, there is a single entry and in_ready_o is combinational from out_ready_i.
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous squash of all held entries.
- in_valid_i  in  1  EX presents a valid instruction.
- in_ready_o  out  1  stage can accept this cycle.
- aluc_i / rD2_i / ext_i / pc4_i  in  XLEN each  EX payload.
- wR_i  in  REG_AW  destination register.
- rf_wsel_i  in  WSEL_W  write-back source select.
- rf_we_i, ram_we_i  in  1 each  register-file / RAM write enables.
- out_valid_o  out  1  MEM-side entry valid.
- out_ready_i  in  1  MEM consumes this cycle.
- aluc_o / rD2_o / ext_o / pc4_o / wR_o / rf_wsel_o  out  as inputs  head-entry payload.
- rf_we_o, ram_we_o  out  1  head-entry enables, gated by out_valid_o.
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Reset (rst_i high, asynchronous):
  - All payload registers, both valid bits and stall_cnt_o go to 0.
  - out_valid_o=0, rf_we_o=0, ram_we_o=0.
  - Reset dominates flush and all handshakes.
- Handshake definitions:
  - Accept = in_valid_i & in_ready_o.
  - Retire = out_valid_o & out_ready_i.
  - Payload is sampled on the accept edge.
  - Latency from accept to out_valid_o is 1 cycle when the stage is empty.
- SKID=1 (entries: head H, skid S):
  - in_ready_o = ~S.valid (registered).
  - Accept with H empty, or H retiring with S empty → data to H.
  - Accept with H full and not retiring → data to S.
  - Retire with S full → S moves to H the same edge. Any simultaneous accept is impossible because in_ready_o=0.
  - Retire with no accept → H.valid=0.
  - Throughput is 1/cycle with zero combinational ready path.
  - Order is strictly FIFO.
- SKID=0 (single entry H):
  - in_ready_o = ~H.valid | out_ready_i.
  - Accept and retire on the same edge replace H.
- Flush (flush_i high at an edge):
  - H.valid and S.valid both cleared.
  - Any accept in the same cycle is discarded.
  - Payload fields keep their old values; only valid is cleared.
  - rf_we_o and ram_we_o read 0 on the following cycle.
- Output gating:
  - rf_we_o = H.rf_we & H.valid; ram_we_o = H.ram_we & H.valid.
  - Other payload outputs show H contents regardless of valid and hold when not valid.
- Stall counter:
  - Increments on each edge with out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; not cleared by flush.
- Boundary: out_ready_i while out_valid_o=0 has no effect. in_valid_i while in_ready_o=0 is ignored, and EX must hold its data.

Test Plan:
- Streaming: SKID=1, out_ready_i=1, 4 back-to-back accepts with aluc_i=0x10,0x20,0x30,0x40 → aluc_o shows the same sequence 1 cycle later, out_valid_o continuously 1, stall_cnt_o=0.
- Back-pressure: SKID=1, accept 0xA then 0xB while out_ready_i=0 → in_ready_o=0 after 2nd accept, aluc_o=0xA held, stall_cnt_o counts per held cycle. Raising out_ready_i → 0xA then 0xB retire in order, in_ready_o returns to 1.
- Flush: H and S full with rf_we=1, ram_we=1, pulse flush_i with in_valid_i=1 → next cycle out_valid_o=0, rf_we_o=0, ram_we_o=0, flushed input not delivered, in_ready_o=1.
- SKID=0: out_valid_o=1, out_ready_i=1, in_valid_i=1 with pc4_i=0x104 → in_ready_o=1 in the same cycle, pc4_o=0x104 next cycle, no bubble.
- Saturation: CNT_W=4, hold a valid entry with out_ready_i=0 for 20 cycles → stall_cnt_o stops at 15.
- Async reset: assert rst_i mid-cycle with entries valid → out_valid_o, rf_we_o, ram_we_o and stall_cnt_o go to 0 immediately without waiting for a clock edge, and in_ready_o=1 after release.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating back-pressure counter.
module ex_mem_pipe_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int WSEL_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   aluc_i,
    input  logic [XLEN-1:0]   rD2_i,
    input  logic [XLEN-1:0]   ext_i,
    input  logic [XLEN-1:0]   pc4_i,
    input  logic [REG_AW-1:0] wR_i,
    input  logic [WSEL_W-1:0] rf_wsel_i,
    input  logic              rf_we_i,
    input  logic              ram_we_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   aluc_o,
    output logic [XLEN-1:0]   rD2_o,
    output logic [XLEN-1:0]   ext_o,
    output logic [XLEN-1:0]   pc4_o,
    output logic [REG_AW-1:0] wR_o,
    output logic [WSEL_W-1:0] rf_wsel_o,
    output logic              rf_we_o,
    output logic              ram_we_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0]   aluc;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   ext;
        logic [XLEN-1:0]   pc4;
        logic [REG_AW-1:0] wr;
        logic [WSEL_W-1:0] rf_wsel;
        logic              rf_we;
        logic              ram_we;
    } payload_t;

    payload_t         payload_in;
    payload_t         h_data_reg;
    logic             h_valid_reg;
    logic             accept;
    logic             retire;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign payload_in = '{aluc: aluc_i, rd2: rD2_i, ext: ext_i, pc4: pc4_i,
                          wr: wR_i, rf_wsel: rf_wsel_i,
                          rf_we: rf_we_i, ram_we: ram_we_i};

    assign accept = in_valid_i & in_ready_o;
    assign retire = h_valid_reg & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            payload_t s_data_reg;
            logic     s_valid_reg;

            // Ready depends only on the skid slot, so no combinational path from out_ready_i.
            assign in_ready_o = ~s_valid_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    h_valid_reg <= 1'b0;
                    s_valid_reg <= 1'b0;
                    h_data_reg  <= '0;
                    s_data_reg  <= '0;
                end else if (flush_i) begin
                    h_valid_reg <= 1'b0;
                    s_valid_reg <= 1'b0;
                end else if (s_valid_reg) begin
                    // Skid full implies head full and no accept this cycle.
                    if (retire) begin
                        h_data_reg  <= s_data_reg;
                        s_valid_reg <= 1'b0;
                    end
                end else if (accept) begin
                    if (!h_valid_reg || retire) begin
                        h_data_reg  <= payload_in;
                        h_valid_reg <= 1'b1;
                    end else begin
                        s_data_reg  <= payload_in;
                        s_valid_reg <= 1'b1;
                    end
                end else if (retire) begin
                    h_valid_reg <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready_o = ~h_valid_reg | out_ready_i;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    h_valid_reg <= 1'b0;
                    h_data_reg  <= '0;
                end else if (flush_i) begin
                    h_valid_reg <= 1'b0;
                end else if (accept) begin
                    h_data_reg  <= payload_in;
                    h_valid_reg <= 1'b1;
                end else if (retire) begin
                    h_valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (h_valid_reg && !out_ready_i && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign out_valid_o = h_valid_reg;
    assign aluc_o      = h_data_reg.aluc;
    assign rD2_o       = h_data_reg.rd2;
    assign ext_o       = h_data_reg.ext;
    assign pc4_o       = h_data_reg.pc4;
    assign wR_o        = h_data_reg.wr;
    assign rf_wsel_o   = h_data_reg.rf_wsel;
    assign rf_we_o     = h_data_reg.rf_we & h_valid_reg;
    assign ram_we_o    = h_data_reg.ram_we & h_valid_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule
